// File: rtl/stepper_scheduler.sv
// stepper_scheduler
//   Sequencing and round-robin arbitration controller for the four-channel
//   stepper bus. After reset it initialises motors 0..3 (counter reset, awake,
//   full-step), then accepts move commands and emits step writes at the
//   commanded tick rate. All channels share one 8-bit control byte qualified
//   by a one-cycle wr strobe; at most one channel is granted per cycle.
//
//   Optional feature macro: STEPPER_AUTOSLEEP_EN
//     When defined, a channel that completes or is aborted issues one extra
//     sleep write; the next step write to that channel wakes it again.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only once init is finished)
//   cmd_chan/dir/half command target channel and motor mode bits
//   cmd_steps         steps to run, 0 aborts the channel
//   cmd_period        timebase ticks between steps, 0 = back to back
//   control, wr       motor bus byte and its one-cycle write strobe
//   busy              per channel: steps still outstanding
//   done              per channel: pulse alongside the final step write
module stepper_scheduler #(
  parameter int PRESCALE = 1000,
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_chan,
  input  logic                cmd_dir,
  input  logic                cmd_half,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  output logic [7:0]          control,
  output logic                wr,
  output logic [3:0]          busy,
  output logic [3:0]          done
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, RUN} state_t;

  state_t state, state_nx;

  logic [PS_W-1:0]               ps_cnt;
  logic                          tick;
  logic [3:0][COUNT_W-1:0]       remaining, rem_nx;
  logic [3:0][PERIOD_W-1:0]      period, timer;
  logic [3:0]                    dir, half, sleep_req;
  logic [3:0]                    accept_oh, step_req, req, gnt_oh, step_gnt;
  logic                          accept, gnt_vld;
  logic [1:0]                    ptr, gnt_ch, idx;
  logic                          wr_nx;
  logic [7:0]                    ctl_nx;

  assign accept = cmd_valid && cmd_ready;

  // Timebase prescaler
  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset)     ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + PS_W'(1);
  end

  // Request vector. A channel taking a command this cycle sits out the
  // arbitration so a stale step never goes out after a retarget/abort.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      accept_oh[i] = accept && (cmd_chan == 2'(i));
      step_req[i]  = (remaining[i] != '0) && (timer[i] == '0);
      req[i]       = (step_req[i] || sleep_req[i]) && !accept_oh[i] && (state == RUN);
    end
  end

  // Round-robin: lowest offset from ptr wins, so scan offsets high to low.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = ptr;
    idx     = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      gnt_oh[i]   = gnt_vld && (gnt_ch == 2'(i));
      step_gnt[i] = gnt_oh[i] && step_req[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        ptr <= 2'd0;
    else if (gnt_vld) ptr <= gnt_ch + 2'd1;
  end

  // Channel state
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rem_nx[i] = remaining[i];
      if (accept_oh[i])     rem_nx[i] = cmd_steps;
      else if (step_gnt[i]) rem_nx[i] = remaining[i] - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      timer     <= '0;
      period    <= '0;
      dir       <= '0;
      half      <= '0;
      busy      <= '0;
      done      <= '0;
    end else begin
      remaining <= rem_nx;
      for (int i = 0; i < 4; i++) begin
        busy[i] <= (rem_nx[i] != '0);
        done[i] <= step_gnt[i] && (remaining[i] == COUNT_W'(1));
        if (accept_oh[i]) begin
          dir[i]    <= cmd_dir;
          half[i]   <= cmd_half;
          period[i] <= cmd_period;
          timer[i]  <= '0;
        end else if (step_gnt[i]) begin
          timer[i]  <= period[i];
        end else if (tick && (timer[i] != '0)) begin
          timer[i]  <= timer[i] - PERIOD_W'(1);
        end
      end
    end
  end

`ifdef STEPPER_AUTOSLEEP_EN
  // Sleep is requested on completion or abort, dropped once written or when
  // a new command arrives; a step write implicitly wakes the motor.
  always_ff @(posedge clk) begin
    if (reset) begin
      sleep_req <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept_oh[i])     sleep_req[i] <= (cmd_steps == '0);
        else if (step_gnt[i]) sleep_req[i] <= (remaining[i] == COUNT_W'(1));
        else if (gnt_oh[i])   sleep_req[i] <= 1'b0;
      end
    end
  end
`else
  assign sleep_req = '0;
`endif

  // Sequencer FSM
  always_ff @(posedge clk) begin
    if (reset) state <= INIT0;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_nx    = 1'b0;
    ctl_nx   = control;
    case (state)
      INIT0: begin wr_nx = 1'b1; ctl_nx = 8'h10; state_nx = INIT1; end
      INIT1: begin wr_nx = 1'b1; ctl_nx = 8'h30; state_nx = INIT2; end
      INIT2: begin wr_nx = 1'b1; ctl_nx = 8'h50; state_nx = INIT3; end
      INIT3: begin wr_nx = 1'b1; ctl_nx = 8'h70; state_nx = RUN;   end
      RUN: begin
        if (gnt_vld) begin
          wr_nx = 1'b1;
          if (step_req[gnt_ch])
            ctl_nx = {1'b0, gnt_ch, 2'b00, half[gnt_ch], dir[gnt_ch], 1'b1};
          else
            ctl_nx = {1'b0, gnt_ch, 2'b01, half[gnt_ch], dir[gnt_ch], 1'b0};
        end
      end
      default: state_nx = INIT0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      control   <= 8'h00;
      wr        <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      control   <= ctl_nx;
      wr        <= wr_nx;
      cmd_ready <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_stepper_scheduler.sv
// Testbench for stepper_scheduler. Commands are turned into per-channel lists
// of expected bus bytes; a monitor pops and checks every write as it appears.
module tb_stepper_scheduler;
  localparam int P = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_chan = 2'd0;
  logic        cmd_dir = 1'b0, cmd_half = 1'b0;
  logic [15:0] cmd_steps = '0, cmd_period = '0;
  logic [7:0]  control;
  logic        wr;
  logic [3:0]  busy, done;

  stepper_scheduler #(.PRESCALE(P), .PERIOD_W(16), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .control(control), .wr(wr), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] ctl;
    bit         last;
    bit         step;
    bit         first;
    int         per;
    int         acc;
  } exp_t;

  exp_t sb[4][$];
  int   vecs = 0, errs = 0;
  bit   mon_en = 0, rot_en = 0;
  int   rot_prev = -1, rot_cnt = 0;
  int   last_wr[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_busy();
    logic [3:0] b = '0;
    for (int c = 0; c < 4; c++)
      foreach (sb[c][j]) if (sb[c][j].step) b[c] = 1'b1;
    return b;
  endfunction

  function automatic int pending();
    return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
  endfunction

  // Monitor / scoreboard
  int   mch, gap;
  exp_t me;
  always @(negedge clk) begin
    if (reset) chk("wr_in_reset", {31'b0, wr}, 32'd0);
    if (mon_en) begin
      if (wr) begin
        mch = int'(control[6:5]);
        chk("wr_expected", {31'b0, sb[mch].size() != 0}, 32'd1);
        if (sb[mch].size() != 0) begin
          me = sb[mch].pop_front();
          chk("control", {24'b0, control}, {24'b0, me.ctl});
          chk("done_on_wr", {28'b0, done}, me.last ? (32'd1 << mch) : 32'd0);
          if (me.step) begin
            if (me.first) begin
              gap = cyc - me.acc;
              chk("first_latency_2to5", {31'b0, gap >= 2 && gap <= 5}, 32'd1);
            end else if (me.per > 0) begin
              gap = cyc - last_wr[mch];
              chk("step_spacing", {31'b0, gap >= (me.per - 1) * P + 2 && gap <= me.per * P + 4}, 32'd1);
            end
            last_wr[mch] = cyc;
          end
        end
        if (rot_en) begin
          if (rot_prev >= 0) chk("rotation", mch, (rot_prev + 1) % 4);
          rot_prev = mch;
          rot_cnt++;
        end
      end else begin
        chk("done_idle", {28'b0, done}, 32'd0);
      end
      chk("busy", {28'b0, busy}, {28'b0, exp_busy()});
    end
  end

  // Issue one command; expectations are logged once it has been accepted.
  task automatic send(input int ch, input bit d, input bit h, input int steps, input int per);
    int   guard = 0;
    exp_t e;
    logic [1:0] c2;
    c2 = ch[1:0];
    @(negedge clk);
    while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_chan = c2; cmd_dir = d; cmd_half = h;
    cmd_steps = 16'(steps); cmd_period = 16'(per);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    sb[ch].delete();
    for (int k = 0; k < steps; k++) begin
      e.ctl = {1'b0, c2, 2'b00, h, d, 1'b1};
      e.last = (k == steps - 1); e.step = 1'b1; e.first = (k == 0);
      e.per = per; e.acc = cyc - 1;
      sb[ch].push_back(e);
    end
`ifdef STEPPER_AUTOSLEEP_EN
    e.ctl = {1'b0, c2, 2'b01, h, d, 1'b0};
    e.last = 1'b0; e.step = 1'b0; e.first = 1'b0; e.per = per; e.acc = cyc - 1;
    sb[ch].push_back(e);
`endif
  endtask

  task automatic drain();
    int t = 0;
    while (t < 3000 && pending() != 0) begin @(negedge clk); t++; end
    chk("drain_timeout", {31'b0, t < 3000}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < 4; c++) last_wr[c] = 0;
    // Reset and init sequence
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("init_wr", {31'b0, wr}, 32'd1);
      chk("init_control", {24'b0, control}, 32'h10 + 32'(32 * (k - 1)));
      chk("init_cmd_ready", {31'b0, cmd_ready}, (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("post_init_wr", {31'b0, wr}, 32'd0);
    chk("post_init_busy", {28'b0, busy}, 32'd0);
    mon_en = 1'b1;

    // Ch2: 3 steps, period 2, dir 1, first write exactly two cycles later
    send(2, 1'b1, 1'b0, 3, 2);
    @(negedge clk);
    @(negedge clk);
    chk("ch2_first_wr", {31'b0, wr}, 32'd1);
    chk("ch2_first_ctl", {24'b0, control}, 32'h43);
    drain();

    // All four channels, period 0: strict rotation, 20 writes
    rot_en = 1'b1; rot_prev = -1; rot_cnt = 0;
    for (int c = 0; c < 4; c++) send(c, 1'b0, 1'b0, 5, 0);
    drain();
    rot_en = 1'b0;
    chk("rotation_count", rot_cnt, 32'd20);

    // Ch1 abort mid-move
    send(1, 1'b0, 1'b1, 100, 1);
    repeat (20) @(negedge clk);
    send(1, 1'b0, 1'b0, 0, 0);
    repeat (40) @(negedge clk);
    chk("abort_busy1", {31'b0, busy[1]}, 32'd0);
    drain();

    // Retarget ch0 while it is contending every other cycle
    send(0, 1'b0, 1'b0, 40, 0);
    send(1, 1'b1, 1'b0, 40, 0);
    repeat (5) @(negedge clk);
    send(0, 1'b1, 1'b1, 6, 0);
    send(0, 1'b0, 1'b1, 6, 0);
    drain();

`ifdef STEPPER_AUTOSLEEP_EN
    // Single step then sleep on ch3, then wake on the next command
    send(3, 1'b0, 1'b0, 1, 0);
    drain();
    send(3, 1'b1, 1'b0, 2, 1);
    drain();
`endif

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      send(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    drain();
    chk("final_busy", {28'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/stepper_scheduler.md
# stepper_scheduler

Sequencing and arbitration controller for the four-channel stepper bus. It accepts move commands (channel, direction, mode, step count, step period) and generates step and sleep writes at the commanded rate. All four channels share one 8-bit control byte with a one-cycle `wr` strobe, so writes are arbitrated round-robin. It sits between the serial command decoder and the four `motor` instances (IDX 0..3).

## Interface
- `PRESCALE`, default 1000: clk cycles per timebase tick (≥1).
- `PERIOD_W`, default 16: width of the step period, in ticks.
- `COUNT_W`, default 16: width of the step count.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_chan`  in  2  target channel.
- `cmd_dir`  in  1  step direction (motor `dir` bit).
- `cmd_half`  in  1  half-step mode.
- `cmd_steps`  in  COUNT_W  steps to run; 0 = abort.
- `cmd_period`  in  PERIOD_W  ticks between steps; 0 = as fast as the bus allows.
- `control`  out  8  motor bus byte: [0]step, [1]dir, [2]half, [3]sleep, [4]reset, [6:5]addr, [7]=0.
- `wr`  out  1  bus write strobe, one cycle per byte.
- `busy`  out  4  channel has remaining steps.
- `done`  out  4  one-cycle pulse when the channel's last step is written.

## Operation
- FSM: INIT0..INIT3 → RUN. Reset forces INIT0.
- Each INITn state writes `control = {0, n, 1, 0, 0, 0, 0}` (motor counter reset, awake, full-step), then advances. After INIT3 the FSM enters RUN.
- `cmd_ready` is 1 only in RUN.
- Prescaler counts 0..PRESCALE-1 and emits a 1-cycle `tick` on wrap.
- Per-channel registers: `remaining`, `period`, `timer`, `dir`, `half`.
- `timer` decrements on `tick` and saturates at 0.
- Step request: `remaining != 0 && timer == 0`.
- Command accept: loads `dir`, `half`, `period` and `remaining = cmd_steps`, and sets `timer = 0`. The first step is requested immediately.
- Accepting a command to a busy channel overwrites it (retarget). No `done` pulse is issued for the abandoned move.
- `cmd_steps == 0`: clears `remaining` (abort). `busy` falls, no `done` pulse.
- Arbiter (RUN only): at most one grant per cycle, round-robin starting at last grant + 1 (mod 4). After reset the pointer starts at channel 0.
- A channel receiving a command in the same cycle is excluded from that cycle's grant.
- Step grant:
  - writes `{0, ch, 0, 0, half, dir, 1}`;
  - `remaining -= 1`, `timer <= period`;
  - when `remaining` goes 1→0, `done[ch]` pulses in the same cycle as the `wr` for that step.
- `busy[ch] = (remaining != 0)`, registered.
- Registered outputs reset to 0: `control`, `wr`, `busy`, `done`, `cmd_ready`.
- Prescaler, timers and `remaining` reset to 0.

## Timing
- Reset deasserted in cycle 0: INIT writes for addresses 0..3 appear in cycles 1..4; `cmd_ready` = 1 from cycle 4.
- Command accepted in cycle N on an idle bus: first step `wr` in cycle N+2.
- The following steps of that channel are spaced `period` ticks apart, ± arbitration delay. Each later step is requested the cycle after `timer` reaches 0.
- `period = 0` with k channels requesting gives each channel one write every k cycles.
- Arbitration delay is at most 3 cycles. A pending request is never dropped.
- `wr` is never asserted on two channels in one cycle, and never during reset.

## Configuration
- `STEPPER_AUTOSLEEP_EN` defined:
  - when a channel completes (`done`), a sleep request is set;
  - the channel arbitrates like a step request and writes `{0, ch, 0, 1, half, dir, 0}` (sleep, no step);
  - a command to that channel clears the pending sleep;
  - an abort (`cmd_steps = 0`) also sets the sleep request;
  - the next step write carries sleep = 0, which wakes the motor.
- Undefined: sleep bit is always 0 and no sleep writes are issued.

## Test plan
- Reset released with PRESCALE=4 → `wr` in cycles 1..4 with `control` = 0x10, 0x30, 0x50, 0x70; `cmd_ready` rises in cycle 4.
- Ch2: steps=3, period=2, dir=1, PRESCALE=4 → three `wr` with `control` = 0x43, first at N+2, then spaced 8 cycles; `done[2]` with the third write; `busy[2]` then falls.
- All four channels: period=0, steps=5, same cycle → writes rotate ch0,1,2,3; 20 writes total; each `done` pulses once.
- Ch1 busy with steps=100, then a command with steps=0 → no further ch1 step writes; `busy[1]` = 0; no `done[1]`.
- Command to ch0 in the same cycle ch0 would be granted → grant goes to the next requester; new ch0 parameters are used from the next write.
- `STEPPER_AUTOSLEEP_EN`: ch3 steps=1 → step write 0x61, then sleep write 0x68 (`cmd_half` = 0); the next command's step write has bit 3 = 0.
